pipe_elastic_stage: RTL
=======================

Name: pipe_elastic_stage

Overview:
- Parametrised successor to the fixed-width enable-only pipeline register used between processor stages.
- Adds a valid/ready handshake, a DEPTH-entry elastic buffer, synchronous flush and a defined bubble value.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Lets stall back-pressure be absorbed locally instead of through a global enable.

Parameters:
DATA_WIDTH, 64, width of the payload word (1..256)
DEPTH, 2, number of buffer entries (1..8)
BUBBLE_VALUE, 0, value driven on out_data when out_valid is low (DATA_WIDTH bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
flush  input  1  discard all held entries at next edge
in_valid  input  1  upstream presents a word
in_ready  output  1  stage accepts a word this cycle
in_data  input  DATA_WIDTH  upstream payload
out_valid  output  1  head entry present
out_ready  input  1  downstream consumes head this cycle
out_data  output  DATA_WIDTH  head payload, or BUBBLE_VALUE when empty
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset); all state updates on the rising edge of clk.
- Reset values: count=0; out_valid=0; out_data=BUBBLE_VALUE; read/write pointers=0; in_ready=1 after reset.
  - Reset has priority over flush, push and pop.
  - Reset mid-stream drops all entries.
- Push and pop conditions:
  - Push occurs when in_valid & in_ready.
  - Pop occurs when out_valid & out_ready.
  - Both may occur in the same cycle; count is then unchanged and the pointers both advance.
- in_ready = (count < DEPTH). It is derived only from registered state: no combinational path from out_ready or in_valid.
- out_valid = (count != 0). out_data = entry[rd_ptr] when out_valid, else BUBBLE_VALUE. Both come from registers plus a read mux.
- Latency: a word pushed at edge N is visible on out_data after edge N, i.e. one cycle, provided no older entries are held. Ordering is strictly FIFO.
- Throughput: with DEPTH>=2, one word per cycle is sustained while out_ready=1. With DEPTH=1, throughput is half-rate: the entry must pop before the next push.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two; the pointer resets to 0 after index DEPTH-1.
- Full (count==DEPTH): in_ready=0. Upstream data is held by upstream and no entry is overwritten.
- Empty (count==0): out_valid=0. out_ready is ignored and count never underflows.
- Flush:
  - At the next edge, count=0 and pointers=0; out_valid falls and out_data=BUBBLE_VALUE.
  - Flush has priority over a simultaneous push and pop: the pushed word is discarded and the pop is void.
  - in_ready during a flush cycle still reflects the pre-flush count.
- Stored entries that are not at the head are never observable. Their contents after flush or reset are don't-care.
- Occupancy state (count, pointers, valid) is held in registers. Entry storage may be a register array without reset.

Optional Feature:
- Macro: PIPE_ELASTIC_BYPASS_EN
- Defined: in_ready = (count < DEPTH) | out_ready.
  - When full, a push and a pop may occur in the same cycle.
  - Gives full throughput at DEPTH=1, at the cost of a combinational out_ready->in_ready path.
  - Flush still has priority, and a push in a flush cycle is discarded.
- Undefined: in_ready as specified above, with no combinational ready path.

Test Plan:
1. Reset, then idle with DATA_WIDTH=64, DEPTH=2, BUBBLE_VALUE=0 -> count=0, out_valid=0, out_data=0, in_ready=1.
2. Push 0xA, 0xB, 0xC on consecutive cycles with out_ready=0 -> 0xA and 0xB accepted; in_ready=0 from the cycle count=2; 0xC held upstream. Raise out_ready -> outputs in order 0xA, 0xB, 0xC; count returns to 0.
3. Stream 0x1..0x10 with out_ready=1 continuously -> one output per cycle, each one cycle after its push; count stays 1; no loss or reorder.
4. count=2 holding 0x5, 0x6; assert flush together with in_valid (data 0x7) and out_ready -> next cycle count=0, out_valid=0, out_data=0; 0x7 never appears.
5. DEPTH=3 with random in_valid and out_ready for 1000 cycles -> output sequence equals input sequence; pointer wrap across index 2->0 exercised; count never exceeds 3.
6. DEPTH=1, full, with out_ready=1 and in_valid=1 -> without PIPE_ELASTIC_BYPASS_EN in_ready=0 and no push; with it, push and pop occur in the same cycle and count stays 1.

Source files
------------

// File: rtl/pipe_elastic_stage.sv
// pipe_elastic_stage: elastic pipeline register with a valid/ready handshake and a DEPTH-entry FIFO buffer.
// Latency: a word pushed at edge N appears on out_data after edge N, provided no older entries are held.
// Backpressure: in_ready = (count < DEPTH), which comes from registers only.
//    Build macro PIPE_ELASTIC_BYPASS_EN: ORs out_ready into in_ready, so a full stage can push and pop in one cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset; priority over flush, push and pop
//   flush     empties the buffer at the next edge; a push or pop in the same cycle is discarded
//   in_valid  upstream presents in_data
//   in_ready  stage accepts a word this cycle
//   in_data   upstream payload
//   out_valid head entry present
//   out_ready downstream consumes the head this cycle
//   out_data  head payload, or BUBBLE_VALUE when empty
//   count     current occupancy (0..DEPTH)
module pipe_elastic_stage #(
   parameter int unsigned           DATA_WIDTH   = 64,
   parameter int unsigned           DEPTH        = 2,
   parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned   CW       = $clog2(DEPTH+1);
   // A single-entry buffer still gets a 1-bit pointer; it simply never leaves 0.
   localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         cnt_q;
   logic                  not_full;
   logic                  push;
   logic                  pop;

   // Wrap explicitly at DEPTH-1 so that non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + 1'b1;
   endfunction

   assign not_full  = (cnt_q < DEPTH_C);
   assign out_valid = (cnt_q != '0);

`ifdef PIPE_ELASTIC_BYPASS_EN
   // A pop this cycle frees a slot, so accept even when full.
   assign in_ready = not_full | out_ready;
`else
   assign in_ready = not_full;
`endif

   // Flush overrides both sides: the pushed word is dropped and the pop does not happen.
   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         cnt_q  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Payload storage is not reset; only the head is ever visible, and only while count != 0.
   // When a bypass push lands on a full buffer, wr_ptr == rd_ptr. The slot being vacated is then reused.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   assign out_data = out_valid ? mem[rd_ptr] : BUBBLE_VALUE;
   assign count    = cnt_q;

endmodule
